// File: rtl/wb_commit_queue_pkg.sv
// Shared register-file constants for the writeback commit queue and its FIFO.
package wb_commit_queue_pkg;

    localparam int unsigned REG_BUS_W  = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam logic        WRITEABLE  = 1'b1;
    localparam logic        RST_ENABLE = 1'b1;
    localparam logic [REG_BUS_W-1:0] ZERO_WORD = '0;
    localparam int unsigned WB_DEPTH   = 4;

endpackage

// File: rtl/wb_fifo.sv
// In-order FIFO with two write ports (slot tail, tail+push0) and one read port,
// exposing per-entry valid/address so the top can build the pending mask.
module wb_fifo #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              push0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] data0,
    input  logic              push1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] data1,
    input  logic              pop,
    output logic [ADDR_W-1:0] head_addr,
    output logic [DATA_W-1:0] head_data,
    output logic [CNT_W-1:0]  count,
    output logic [DEPTH-1:0]  entry_valid,
    output logic [ADDR_W-1:0] entry_addr [DEPTH]
);

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [PTR_W-1:0]  slot1;

    // The second write lands directly behind the first, or at tail if the first is absent.
    assign slot1 = tail + PTR_W'(push0);

    always_ff @(posedge clk) begin
        if (rst) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            valid_q <= '0;
        end else if (en) begin
            if (pop) begin
                valid_q[head] <= 1'b0;
                head          <= head + 1'b1;
            end
            if (push0) valid_q[tail]  <= 1'b1;
            if (push1) valid_q[slot1] <= 1'b1;
            tail  <= tail + PTR_W'(push0) + PTR_W'(push1);
            count <= count + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (en && push0) begin
            addr_mem[tail] <= addr0;
            data_mem[tail] <= data0;
        end
        if (en && push1) begin
            addr_mem[slot1] <= addr1;
            data_mem[slot1] <= data1;
        end
    end

    assign head_addr   = addr_mem[head];
    assign head_data   = data_mem[head];
    assign entry_valid = valid_q;
    assign entry_addr  = addr_mem;

endmodule

// File: rtl/wb_commit_queue.sv
// Writeback commit queue: merges load and ALU results in program order and
// drains one entry per cycle into the regfile write port.
module wb_commit_queue
    import wb_commit_queue_pkg::*;
#(
    parameter int unsigned DEPTH  = WB_DEPTH,
    parameter int unsigned DATA_W = REG_BUS_W,
    parameter int unsigned ADDR_W = REG_ADDR_W
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              ld_valid_in,
    input  logic [ADDR_W-1:0] ld_addr_in,
    input  logic [DATA_W-1:0] ld_data_in,
    output logic              ld_ready_out,
    input  logic              alu_valid_in,
    input  logic [ADDR_W-1:0] alu_addr_in,
    input  logic [DATA_W-1:0] alu_data_in,
    output logic              alu_ready_out,
    output logic              write_or_not,
    output logic [ADDR_W-1:0] writeaddr,
    output logic [DATA_W-1:0] writedata,
    output logic [31:0]       pending_mask
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned CMP_W = CNT_W + 1;
    localparam logic [CMP_W-1:0] DEPTH_C = CMP_W'(DEPTH);

    logic              rst_act;
    logic              push0;
    logic              push1;
    logic              pop;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic [CNT_W-1:0]  count;
    logic [DEPTH-1:0]  entry_valid;
    logic [ADDR_W-1:0] entry_addr [DEPTH];

    assign rst_act = (rst_in == RST_ENABLE);

    // Readies look only at registered occupancy; a same-edge pop earns no credit.
    assign ld_ready_out  = !rst_act && rdy_in && ({1'b0, count} < DEPTH_C);
    assign alu_ready_out = !rst_act && rdy_in &&
                           (({1'b0, count} + CMP_W'(ld_valid_in)) < DEPTH_C);

    assign push0 = ld_valid_in  && ld_ready_out  && (ld_addr_in  != '0);
    assign push1 = alu_valid_in && alu_ready_out && (alu_addr_in != '0);
    assign pop   = rdy_in && (count != '0);

    wb_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk         (clk_in),
        .rst         (rst_act),
        .en          (rdy_in),
        .push0       (push0),
        .addr0       (ld_addr_in),
        .data0       (ld_data_in),
        .push1       (push1),
        .addr1       (alu_addr_in),
        .data1       (alu_data_in),
        .pop         (pop),
        .head_addr   (head_addr),
        .head_data   (head_data),
        .count       (count),
        .entry_valid (entry_valid),
        .entry_addr  (entry_addr)
    );

    always_ff @(posedge clk_in) begin
        if (rst_act) begin
            write_or_not <= 1'b0;
            writeaddr    <= '0;
            writedata    <= DATA_W'(ZERO_WORD);
        end else if (pop) begin
            write_or_not <= WRITEABLE;
            writeaddr    <= head_addr;
            writedata    <= head_data;
        end else begin
            write_or_not <= 1'b0;
        end
    end

    always_comb begin
        pending_mask = '0;
        if (!rst_act) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (entry_valid[i]) pending_mask[entry_addr[i]] = 1'b1;
            end
            if (write_or_not) pending_mask[writeaddr] = 1'b1;
            pending_mask[0] = 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_commit_queue.sv
// Directed bench for wb_commit_queue with a scoreboard of expected regfile writes.
module tb_wb_commit_queue;

    logic        clk = 1'b0;
    logic        rst_in, rdy_in;
    logic        ld_valid_in, alu_valid_in;
    logic [4:0]  ld_addr_in, alu_addr_in;
    logic [31:0] ld_data_in, alu_data_in;
    logic        ld_ready_out, alu_ready_out;
    logic        write_or_not;
    logic [4:0]  writeaddr;
    logic [31:0] writedata;
    logic [31:0] pending_mask;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t sb[$];
    int   total  = 0;
    int   passed = 0;
    int   failed = 0;

    always #5 clk = ~clk;

    wb_commit_queue #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut (
        .clk_in        (clk),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .ld_valid_in   (ld_valid_in),
        .ld_addr_in    (ld_addr_in),
        .ld_data_in    (ld_data_in),
        .ld_ready_out  (ld_ready_out),
        .alu_valid_in  (alu_valid_in),
        .alu_addr_in   (alu_addr_in),
        .alu_data_in   (alu_data_in),
        .alu_ready_out (alu_ready_out),
        .write_or_not  (write_or_not),
        .writeaddr     (writeaddr),
        .writedata     (writedata),
        .pending_mask  (pending_mask)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Every presented write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (write_or_not === 1'b1) begin
            total++;
            assert (sb.size() > 0) passed++;
            else begin
                failed++;
                $error("FAIL sb_unexpected_write: observed addr=%0d data=%0h expected none", writeaddr, writedata);
            end
            if (sb.size() > 0) begin
                ent_t e;
                e = sb.pop_front();
                chk("sb_addr", 64'(writeaddr), 64'(e.a));
                chk("sb_data", 64'(writedata), 64'(e.d));
            end
        end
    end

    initial begin
        int unsigned mc;
        logic lv, av, la, aa, pp;
        logic [31:0] seq;
        seq = 32'h1000;

        rst_in = 1'b1; rdy_in = 1'b1;
        ld_valid_in = 1'b1; ld_addr_in = 5'd1; ld_data_in = '0;
        alu_valid_in = 1'b1; alu_addr_in = 5'd2; alu_data_in = '0;
        repeat (2) step();
        chk("rst_wr", 64'(write_or_not), 64'd0);
        chk("rst_waddr", 64'(writeaddr), 64'd0);
        chk("rst_wdata", 64'(writedata), 64'd0);
        chk("rst_mask", 64'(pending_mask), 64'd0);
        chk("rst_ld_ready", 64'(ld_ready_out), 64'd0);
        chk("rst_alu_ready", 64'(alu_ready_out), 64'd0);
        chk("rst_count", 64'(dut.count), 64'd0);

        // single ALU push
        rst_in = 1'b0; ld_valid_in = 1'b0;
        alu_addr_in = 5'd5; alu_data_in = 32'h1234_5678;
        #1;
        chk("t1_alu_ready", 64'(alu_ready_out), 64'd1);
        sb.push_back('{5'd5, 32'h1234_5678});
        step();
        alu_valid_in = 1'b0;
        chk("t1_mask_q", 64'(pending_mask), 64'h20);
        chk("t1_wr_q", 64'(write_or_not), 64'd0);
        step();
        chk("t1_wr", 64'(write_or_not), 64'd1);
        chk("t1_waddr", 64'(writeaddr), 64'd5);
        chk("t1_wdata", 64'(writedata), 64'h1234_5678);
        chk("t1_mask_out", 64'(pending_mask), 64'h20);
        step();
        chk("t1_idle", 64'(write_or_not), 64'd0);
        chk("t1_mask_idle", 64'(pending_mask), 64'd0);

        // same-cycle load and ALU to one register: load is older
        ld_valid_in = 1'b1; ld_addr_in = 5'd3; ld_data_in = 32'hAAAA;
        alu_valid_in = 1'b1; alu_addr_in = 5'd3; alu_data_in = 32'hBBBB;
        sb.push_back('{5'd3, 32'hAAAA});
        sb.push_back('{5'd3, 32'hBBBB});
        step();
        ld_valid_in = 1'b0; alu_valid_in = 1'b0;
        chk("t2_count", 64'(dut.count), 64'd2);
        step();
        chk("t2_first", 64'(writedata), 64'hAAAA);
        step();
        chk("t2_second", 64'(writedata), 64'hBBBB);
        chk("t2_second_wr", 64'(write_or_not), 64'd1);
        step();
        chk("t2_idle", 64'(write_or_not), 64'd0);

        // burst: both valid for several cycles, then random valids
        mc = 0;
        for (int i = 0; i < 14; i++) begin
            lv = (i < 6) ? 1'b1 : ($urandom_range(0, 3) != 0);
            av = (i < 6) ? 1'b1 : ($urandom_range(0, 3) != 0);
            ld_valid_in = lv; ld_addr_in = 5'($urandom_range(1, 31)); ld_data_in = seq; seq++;
            alu_valid_in = av; alu_addr_in = 5'($urandom_range(1, 31)); alu_data_in = seq; seq++;
            #1;
            la = (mc < 4);
            aa = ((mc + 32'(lv)) < 4);
            chk("burst_ld_ready", 64'(ld_ready_out), 64'(la));
            chk("burst_alu_ready", 64'(alu_ready_out), 64'(aa));
            la = la && lv;
            aa = aa && av;
            if (la) sb.push_back('{ld_addr_in, ld_data_in});
            if (aa) sb.push_back('{alu_addr_in, alu_data_in});
            pp = (mc > 0);
            step();
            mc = mc + 32'(la) + 32'(aa) - 32'(pp);
            chk("burst_count", 64'(dut.count), 64'(mc));
            chk("burst_wr", 64'(write_or_not), 64'(pp));
        end
        ld_valid_in = 1'b0; alu_valid_in = 1'b0;
        repeat (5) step();
        chk("drain_count", 64'(dut.count), 64'd0);
        chk("drain_wr", 64'(write_or_not), 64'd0);

        // x0 is accepted and dropped
        alu_valid_in = 1'b1; alu_addr_in = 5'd0; alu_data_in = 32'hDEAD;
        #1;
        chk("x0_ready", 64'(alu_ready_out), 64'd1);
        step();
        alu_valid_in = 1'b0;
        chk("x0_count", 64'(dut.count), 64'd0);
        chk("x0_mask", 64'(pending_mask), 64'd0);
        step();
        chk("x0_wr", 64'(write_or_not), 64'd0);

        // rdy_in low freezes the queue
        ld_valid_in = 1'b1; ld_addr_in = 5'd7; ld_data_in = 32'h7777;
        alu_valid_in = 1'b1; alu_addr_in = 5'd8; alu_data_in = 32'h8888;
        sb.push_back('{5'd7, 32'h7777});
        sb.push_back('{5'd8, 32'h8888});
        step();
        rdy_in = 1'b0; ld_addr_in = 5'd9; alu_addr_in = 5'd10;
        #1;
        chk("frz_ld_ready", 64'(ld_ready_out), 64'd0);
        chk("frz_alu_ready", 64'(alu_ready_out), 64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("frz_wr", 64'(write_or_not), 64'd0);
            chk("frz_count", 64'(dut.count), 64'd2);
            chk("frz_mask", 64'(pending_mask), 64'h180);
        end
        rdy_in = 1'b1; ld_valid_in = 1'b0; alu_valid_in = 1'b0;
        step();
        chk("frz_resume1", 64'(writeaddr), 64'd7);
        step();
        chk("frz_resume2", 64'(writeaddr), 64'd8);
        step();
        chk("frz_idle", 64'(write_or_not), 64'd0);

        // reset mid-operation with 3 queued entries
        ld_valid_in = 1'b1; ld_addr_in = 5'd9;  ld_data_in = 32'h9;
        alu_valid_in = 1'b1; alu_addr_in = 5'd10; alu_data_in = 32'hA;
        sb.push_back('{5'd9, 32'h9});
        step();
        ld_addr_in = 5'd11; ld_data_in = 32'hB;
        alu_addr_in = 5'd12; alu_data_in = 32'hC;
        step();
        chk("mid_count", 64'(dut.count), 64'd3);
        rst_in = 1'b1; ld_valid_in = 1'b0; alu_valid_in = 1'b0;
        #1;
        chk("mid_rst_mask", 64'(pending_mask), 64'd0);
        chk("mid_rst_ld_ready", 64'(ld_ready_out), 64'd0);
        step();
        chk("mid_count_clr", 64'(dut.count), 64'd0);
        chk("mid_wr_clr", 64'(write_or_not), 64'd0);
        chk("mid_mask_clr", 64'(pending_mask), 64'd0);
        rst_in = 1'b0;
        repeat (4) begin
            step();
            chk("mid_no_write", 64'(write_or_not), 64'd0);
        end

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/wb_commit_queue.md
# wb_commit_queue

Writeback commit queue feeding the register file's single write port. Accepts destination-register results from the ALU path and the load path through valid/ready handshakes and buffers them in a small in-order FIFO. Drains one entry per cycle into the regfile write port (`write_or_not`, `writeaddr`, `writedata`). Exports a pending-destination mask that decode uses for stall decisions.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥ 2
- DATA_W, 32, result width (matches `RegBus`)
- ADDR_W, 5, register index width (matches `RegAddrBus`)

Ports:
- clk_in  in  1  single clock, all state on rising edge
- rst_in  in  1  reset, synchronous, active-high
- rdy_in  in  1  global enable; low freezes queue state
- ld_valid_in  in  1  load result valid
- ld_addr_in  in  ADDR_W  load destination register
- ld_data_in  in  DATA_W  load result
- ld_ready_out  out  1  load result accepted this edge when high with valid
- alu_valid_in  in  1  ALU result valid
- alu_addr_in  in  ADDR_W  ALU destination register
- alu_data_in  in  DATA_W  ALU result
- alu_ready_out  out  1  ALU result accepted this edge when high with valid
- write_or_not  out  1  regfile write enable (`Writeable` when high)
- writeaddr  out  ADDR_W  regfile write index
- writedata  out  DATA_W  regfile write data
- pending_mask  out  32  bit i set when a write to xi is queued or being presented

## Operation
- Program order: a load result is older than a same-cycle ALU result, so the load enqueues first.
- Ready rules use registered occupancy `count` only. Same-cycle pops are not credited.
  - `ld_ready_out = !rst_in && rdy_in && count < DEPTH`
  - `alu_ready_out = !rst_in && rdy_in && count + ld_valid_in < DEPTH`
- Enqueue accepts 0, 1 or 2 entries per edge. The load takes the tail slot; the ALU result takes tail+1.
- x0 requests complete the handshake normally and are discarded: no slot, no write. Ready is still computed as above.
- Drain stage: output registers `write_or_not`, `writeaddr`, `writedata`.
  - On each edge with `rdy_in` high, if count > 0, load the head into the output registers, set `write_or_not = 1` and pop.
  - Otherwise set `write_or_not = 0`. Address and data hold their values.
- Pop and push in the same edge are allowed. The new count is `count + pushes − pop` and never exceeds DEPTH.
- `pending_mask`: OR of the one-hot of every valid FIFO entry, plus the output stage while `write_or_not` is high. Bit 0 is forced to 0. Combinational from registered state.
- Duplicate destinations in the queue are legal. They are written in order, and the youngest value is the one left in the regfile.
- Pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits.

## Timing
- Reset (edge with `rst_in` high): count = 0, pointers = 0, `write_or_not` = 0, `writeaddr` = 0, `writedata` = 0. `pending_mask` = 0 and both readies are 0 while `rst_in` is high.
- Reset mid-operation drops all queued entries; no write is issued for them.
- Latency: a result accepted at edge k is popped at edge k+1 (if it is the head) and written into the regfile at edge k+2. Minimum latency is 2 edges.
- Throughput: 1 write per cycle sustained. Burst input is 2 per cycle until full.
- `rdy_in` low at an edge: no push, no pop, `write_or_not` ← 0. A write already presented in that cycle still lands in the regfile, because the regfile ignores `rdy_in`.
- Full (count = DEPTH): both readies are 0, even when a pop occurs at that edge.
- count = DEPTH−1 with both valid: the load is accepted, the ALU result is stalled.

## Structure
- Shared define header supplies `RegBus`, `RegAddrBus`, `Writeable`, `RstEnable`, `ZeroWorld`. No new typedefs are needed; new constants (DEPTH default) go in the same header.
- One sub-module: `wb_fifo`, a 2-write/1-read synchronous FIFO with count and a per-entry valid/address view used for `pending_mask`.
- The top level holds the ready logic, x0 filter and output registers.

## Test plan
- Reset, then a single ALU push (x5, 0x1234_5678) at edge 1 → `write_or_not` = 1, `writeaddr` = 5, `writedata` = 0x12345678 during the cycle after edge 2; `pending_mask[5]` = 1 from after edge 1 through that cycle.
- Same-cycle load (x3, 0xAAAA) and ALU (x3, 0xBBBB) → two consecutive writes to x3, first 0xAAAA then 0xBBBB.
- Both sources valid every cycle with DEPTH=4 → alu_ready drops at count = 3; both readies are 0 at count = 4; sustained 1 write/cycle; no entry lost or reordered (scoreboard check).
- ALU push to x0 → handshake completes, no write issued, `pending_mask` stays 0, count unchanged.
- Hold `rdy_in` low for 3 cycles with 2 queued entries → readies are 0, `write_or_not` = 0, count holds at 2; draining resumes in order once `rdy_in` returns high.
- Assert `rst_in` with 3 queued entries → the next cycle has count = 0, `write_or_not` = 0, `pending_mask` = 0, and no queued write reaches the regfile.
